// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: serialises single register reads/writes onto MDC/MDIO.
// Read capture is built only when MDIO_READ_EN is defined; otherwise rdata is 0 and reads flag err.
module mdio_master #(
  parameter int MDC_DIV  = 25,
  parameter int PRE_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        op_rd,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  if (MDC_DIV < 2) begin : g_bad_div
    $error("mdio_master: MDC_DIV must be >= 2");
  end

  localparam int HW = (MDC_DIV > 2) ? $clog2(MDC_DIV) : 1;
  localparam int BW = $clog2((PRE_BITS > 16) ? PRE_BITS : 16);

  localparam logic [HW-1:0] H_LAST   = HW'(MDC_DIV - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(PRE_BITS - 1);
  localparam logic [BW-1:0] HDR_LAST = BW'(13);
  localparam logic [BW-1:0] TA_LAST  = BW'(1);
  localparam logic [BW-1:0] DAT_LAST = BW'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  state_t          state_q, state_n;
  logic [HW-1:0]   hcnt_q, hcnt_n;
  logic [BW-1:0]   bcnt_q, bcnt_n;
  logic            mdc_q, mdc_n;
  logic            o_q, o_n;
  logic            oe_q, oe_n;
  logic [13:0]     hdr_q, hdr_n;
  logic [15:0]     sreg_q, sreg_n;
  logic            rd_q, rd_n;
  logic            err_q, err_n;
  logic            bit_last;
`ifdef MDIO_READ_EN
  logic [15:0]     rdata_q, rdata_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      mdc_q   <= 1'b0;
      o_q     <= 1'b1;
      oe_q    <= 1'b0;
      hdr_q   <= '0;
      sreg_q  <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef MDIO_READ_EN
      rdata_q <= '0;
`endif
    end else begin
      state_q <= state_n;
      hcnt_q  <= hcnt_n;
      bcnt_q  <= bcnt_n;
      mdc_q   <= mdc_n;
      o_q     <= o_n;
      oe_q    <= oe_n;
      hdr_q   <= hdr_n;
      sreg_q  <= sreg_n;
      rd_q    <= rd_n;
      err_q   <= err_n;
`ifdef MDIO_READ_EN
      rdata_q <= rdata_n;
`endif
    end
  end

  always_comb begin
    bit_last = 1'b0;
    case (state_q)
      S_PRE:   bit_last = (bcnt_q == PRE_LAST);
      S_HDR:   bit_last = (bcnt_q == HDR_LAST);
      S_TA:    bit_last = (bcnt_q == TA_LAST);
      S_DATA:  bit_last = (bcnt_q == DAT_LAST);
      default: bit_last = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    hcnt_n  = hcnt_q;
    bcnt_n  = bcnt_q;
    mdc_n   = mdc_q;
    o_n     = o_q;
    oe_n    = oe_q;
    hdr_n   = hdr_q;
    sreg_n  = sreg_q;
    rd_n    = rd_q;
    err_n   = err_q;
`ifdef MDIO_READ_EN
    rdata_n = rdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        mdc_n = 1'b0;
        if (req) begin
          state_n = S_PRE;
          hcnt_n  = '0;
          bcnt_n  = '0;
          o_n     = 1'b1;
          oe_n    = 1'b1;
          hdr_n   = {2'b01, (op_rd ? 2'b10 : 2'b01), phy_addr, reg_addr};
          sreg_n  = wdata;
          rd_n    = op_rd;
`ifdef MDIO_READ_EN
          err_n   = 1'b0;
`else
          err_n   = op_rd;
`endif
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        mdc_n   = 1'b0;
      end
      default: begin
        if (hcnt_q != H_LAST) begin
          hcnt_n = hcnt_q + 1'b1;
        end else begin
          hcnt_n = '0;
          if (!mdc_q) begin
            mdc_n = 1'b1;
`ifdef MDIO_READ_EN
            // last low cycle: sample just before MDC rises
            if (rd_q && state_q == S_TA && bcnt_q == TA_LAST)
              err_n = mdio_i;
            if (rd_q && state_q == S_DATA)
              rdata_n = {rdata_q[14:0], mdio_i};
`endif
          end else begin
            mdc_n = 1'b0;
            if (bit_last) begin
              bcnt_n = '0;
              case (state_q)
                S_PRE:   state_n = S_HDR;
                S_HDR:   state_n = S_TA;
                S_TA:    state_n = S_DATA;
                default: state_n = S_DONE;
              endcase
            end else begin
              bcnt_n = bcnt_q + 1'b1;
            end
            // drive the next bit together with the MDC falling edge
            case (state_n)
              S_PRE: begin
                o_n  = 1'b1;
                oe_n = 1'b1;
              end
              S_HDR: begin
                o_n   = hdr_q[13];
                oe_n  = 1'b1;
                hdr_n = {hdr_q[12:0], 1'b0};
              end
              S_TA: begin
                o_n  = rd_q ? 1'b1 : ~bcnt_n[0];
`ifdef MDIO_READ_EN
                oe_n = ~rd_q;
`else
                oe_n = 1'b1;
`endif
              end
              S_DATA: begin
                o_n  = rd_q ? 1'b1 : sreg_q[15];
`ifdef MDIO_READ_EN
                oe_n = ~rd_q;
`else
                oe_n = 1'b1;
`endif
                if (!rd_q)
                  sreg_n = {sreg_q[14:0], 1'b0};
              end
              S_DONE: begin
                o_n  = 1'b1;
                oe_n = 1'b0;
              end
              default: begin
                o_n  = o_q;
                oe_n = oe_q;
              end
            endcase
          end
        end
      end
    endcase
  end

  assign ready   = (state_q == S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign mdc     = mdc_q;
  assign mdio_o  = o_q;
  assign mdio_oe = oe_q;

`ifdef MDIO_READ_EN
  assign rdata = rdata_q;
`else
  logic unused_mdio_i;
  assign unused_mdio_i = mdio_i;
  assign rdata = '0;
`endif

endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management initiator for the GMII Ethernet PHY. It serialises single register read and write requests from `p10_ctrl` (or any control FSM) onto MDC/MDIO and returns read data with a presence/error flag. It sits in `top` beside `eth_vlg`, and the top level builds the bidirectional MDIO pad from `mdio_o`/`mdio_oe`/`mdio_i`. It runs on the 125 MHz `clk` domain.

## Interface

Parameters:

- `MDC_DIV`, default 25: `clk` cycles per MDC half-period. The default gives 2.5 MHz at 125 MHz. Values below 2 are a synthesis-time error.
- `PRE_BITS`, default 32: number of preamble ones sent before ST.

Ports (`clk`, `rst` first). One clock; reset is synchronous and active-high.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  request strobe; accepted when `req && ready`.
- `op_rd`  in  1  1 = read, 0 = write; sampled on accept.
- `phy_addr`  in  5  PHYAD; sampled on accept.
- `reg_addr`  in  5  REGAD; sampled on accept.
- `wdata`  in  16  write data; sampled on accept.
- `ready`  out  1  idle and able to accept a request.
- `done`  out  1  one-cycle pulse at transaction end.
- `rdata`  out  16  read data; valid while `done`=1 and held until the next accept.
- `err`  out  1  read turnaround error; valid with `done`.
- `mdc`  out  1  management clock.
- `mdio_o`  out  1  MDIO output value.
- `mdio_oe`  out  1  MDIO output enable.
- `mdio_i`  in  1  MDIO pad input.

## Operation

- **Frame.** Each transaction is PRE_BITS ones, then ST=01, then OP (01 write, 10 read), then PHYAD[4:0], then REGAD[4:0], then TA, then DATA[15:0]. All fields are sent MSB first. With the default parameters a frame is 64 bits.
- **TA and DATA, write.** TA is driven as 10 and DATA as `wdata`. `mdio_oe`=1 for the whole frame.
- **TA and DATA, read.** `mdio_oe` drops to 0 at the start of the first TA bit and stays 0 through DATA. The second TA bit is sampled; if it reads 1, `err`=1. DATA is shifted into `rdata` MSB first.
- **States.**
  - IDLE: `ready`=1. On accept, go to PRE.
  - PRE → HDR after PRE_BITS bits.
  - HDR → TA after 14 bits.
  - TA → DATA after 2 bits.
  - DATA → DONE after 16 bits.
  - DONE lasts one cycle (`done`=1), then IDLE.
- **Requests while busy.** `req` outside IDLE is ignored and not queued.
- **Request latching.** Request fields are captured into a 16-bit shift register plus header registers on accept. Later changes to the inputs have no effect on the frame in progress.
- **Reset mid-frame.** `rst` forces IDLE on the next edge. `mdc`=0 and `mdio_oe`=0 immediately; the aborted frame is abandoned and no `done` is generated.

## Timing

- **Reset values.**
  - `ready` 1
  - `done` 0
  - `rdata` 0
  - `err` 0
  - `mdc` 0
  - `mdio_o` 1
  - `mdio_oe` 0
- **Bit cell.** Each bit is MDC_DIV cycles with `mdc`=0, then MDC_DIV cycles with `mdc`=1. A half-period counter counts 0..MDC_DIV-1 and wraps.
- **Drive point.** `mdio_o`/`mdio_oe` change only on the first cycle of the low phase, i.e. with the MDC falling edge or the frame start. This gives MDC_DIV cycles of setup before the rising edge.
- **Sample point.** `mdio_i` is sampled on the last cycle of the low phase, immediately before `mdc` rises.
- **Accept to first bit.** `mdc`, `mdio_o` and `mdio_oe` reflect bit 0 of the preamble on the cycle after accept. `ready` goes 0 on that same cycle.
- **Frame length.** (PRE_BITS+32)·2·MDC_DIV cycles. `done` is asserted on the cycle after the last high phase ends; with default parameters that is cycle 3201 after accept.
- **Back-to-back.** `ready` is 1 in the cycle after `done`. A `req` in that cycle starts the next frame, so the minimum inter-frame gap is 1 cycle plus IDLE (`mdc`=0, `mdio_oe`=0).
- **Output idle levels.** `mdc` is held 0 in IDLE and DONE. `mdio_oe` returns to 0 in DONE for both writes and reads.

## Configuration

Macro: `MDIO_READ_EN`.

- **Defined:** full read support as described (TA release, sampling, `rdata`, `err`).
- **Undefined:** the input capture path and `rdata` shift logic are removed, and `rdata` is tied to 0. A read request still runs a full frame, but `mdio_oe` stays 1 with `mdio_o`=1 through TA and DATA. It completes with `done`=1 and `err`=1. Writes are unchanged.

## Test plan

- **Write, MDC_DIV=2.** Write PHY 1, reg 0, data 0x1140. On each MDC rising edge, `mdio` must carry 32 ones, then 01 01 00001 00000 10, then 0001000101000000. `done` must pulse at cycle 257 after accept, and `mdio_oe`=1 throughout.
- **Read.** Read PHY 1, reg 2, with a PHY model driving TA=Z0 and data 0x0022. `mdio_oe` must be 0 from the TA bit 1 low phase onward. The result must be `rdata`=0x0022, `err`=0.
- **Absent PHY.** Read with `mdio_i` held 1. The result must be `rdata`=0xFFFF, `err`=1.
- **Reset mid-frame.** Assert `rst` for 1 cycle at bit 40 of a write. Next cycle: `mdc`=0, `mdio_oe`=0, `ready`=1. No `done` is produced. A following write must complete correctly.
- **Back-to-back and busy requests.** Issue `req` in the cycle after `done`; a second frame must start with a 1-cycle gap. A `req` pulsed mid-frame must be ignored: exactly 2 `done` pulses in total.
- **Default divider.** With MDC_DIV=25, the measured `mdc` period must be 50 cycles at 50% duty, and the frame length 3200 cycles.
